// File: rtl/ifetch_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : ifetch_pkg                                                 |
// | Desc    : Shared types and constants for the instruction-fetch block |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package ifetch_pkg;

  // Width of one instruction word in bytes; the PC advances by this amount.
  localparam int INSTR_BYTES = 4;

  // One prefetched slot: the address it came from and the word read there.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// +----------------------------------------------------------------------+
// | Module  : ifetch_fifo                                                |
// | Desc    : DEPTH-entry synchronous FIFO of fetch entries with flush.  |
// |           Flush dominates push; push at full is accepted only when   |
// |           a pop frees a slot in the same cycle.                      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata   = mem[rd_ptr];

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; flush returns the FIFO to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_ctrl.sv
// +----------------------------------------------------------------------+
// | Module  : ifetch_ctrl                                                |
// | Desc    : Instruction-fetch sequencer. Owns the fetch PC, reads the  |
// |           combinational ROM and buffers {pc, instr} pairs for decode |
// |           over valid/ready. Handles redirects, halts and misaligned  |
// |           redirect targets.                                          |
// |           Build option IFETCH_PERF_EN enables the fetch/flush perf   |
// |           counters; without it both counter ports read zero.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] IMEM_BYTES = 32'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [1:0]  state_o,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  fetch_state_t             state;
  fetch_state_t             state_nxt;
  logic [31:0]              pc_q;
  logic                     fetch_en;
  logic                     redir;
  logic                     misal;
  logic                     pop;
  logic                     push;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  fetch_entry_t             head;
  fetch_entry_t             last_q;
  fetch_entry_t             wentry;

  // A redirect only acts once fetch has been started; misalignment is
  // judged on the target's low two bits.
  assign redir     = redirect_valid & (state != IDLE);
  assign misal     = redir & (redirect_pc[1:0] != 2'b00);
  assign out_valid = ~empty & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign push      = fetch_en & (~full | pop) & ~redirect_valid & (pc_q < IMEM_BYTES);
  assign imem_addr = pc_q;
  assign wentry    = '{pc: pc_q, instr: imem_rdata};

  // When the FIFO runs dry the outputs keep showing the last head entry.
  assign out_pc    = empty ? last_q.pc    : head.pc;
  assign out_instr = empty ? last_q.instr : head.instr;

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: misaligned redirect and halt_req beat start.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (misal || halt_req) state_nxt = HALT;
      HALT:    if (!misal && start && !halt_req && !misalign_err) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    state_o  = state;
    fetch_en = (state == RUN);
  end

  // Fetch PC: aligned redirects load the target, pushes step one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redir && !misal) begin
      pc_q <= redirect_pc;
    end else if (push) begin
      pc_q <= pc_q + 32'(INSTR_BYTES);
    end
  end

  // Sticky fault flag and last-shown head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      last_q       <= '0;
    end else begin
      if (misal) begin
        misalign_err <= 1'b1;
      end
      if (!empty) begin
        last_q <= head;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_q;
  logic [31:0] flush_q;

  // Perf counters: pushes, and entries thrown away by redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      if (push) begin
        fetch_q <= fetch_q + 32'd1;
      end
      if (redir) begin
        flush_q <= flush_q + 32'(count);
      end
    end
  end

  assign fetch_cnt = fetch_q;
  assign flush_cnt = flush_q;
`else
  logic unused_count;
  assign unused_count = ^count;
  assign fetch_cnt    = '0;
  assign flush_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
// +----------------------------------------------------------------------+
// | Module  : tb_ifetch_ctrl                                             |
// | Desc    : Self-checking bench for ifetch_ctrl: directed scenarios    |
// |           plus random stimulus against a queue-based fetch model.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ifetch_ctrl;

  localparam int          DEPTH      = 2;
  localparam logic [31:0] IMEM_BYTES = 32'd100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  state_o;
  logic        misalign_err;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  ifetch_ctrl #(
    .RESET_PC   (32'd0),
    .DEPTH      (DEPTH),
    .IMEM_BYTES (IMEM_BYTES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .state_o        (state_o),
    .misalign_err   (misalign_err),
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  // ROM contents: program words at the addresses exercised directly, hash elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h00500513;
      32'd4:   return 32'h06400093;
      32'd8:   return 32'h20000113;
      32'd92:  return 32'h00100513;
      32'd96:  return 32'h00008067;
      default: return (a * 32'h9E3779B1) ^ 32'h00000013;
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  int          m_state;      // 0 idle, 1 run, 2 halt
  logic [31:0] m_pc;
  bit          m_err;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_instr;

  function automatic void model_reset();
    q.delete();
    m_state = 0; m_pc = 32'd0; m_err = 1'b0;
    m_fetch = 32'd0; m_flush = 32'd0; m_last_pc = 32'd0; m_last_instr = 32'd0;
  endfunction

  // Advance the model across one clock edge using the currently driven inputs.
  function automatic void model_edge();
    bit ov, pp, ps, rd, mis;
    int ns;
    ov  = (q.size() > 0) && !redirect_valid;
    pp  = ov && out_ready;
    ps  = (m_state == 1) && ((q.size() < DEPTH) || pp) && !redirect_valid && (m_pc < IMEM_BYTES);
    rd  = redirect_valid && (m_state != 0);
    mis = rd && (redirect_pc % 4 != 0);
    ns  = m_state;
    if (m_state == 0) begin
      if (start) ns = 1;
    end else if (mis) begin
      ns = 2;
    end else if (m_state == 1) begin
      if (halt_req) ns = 2;
    end else if (start && !halt_req && !m_err) begin
      ns = 1;
    end
    if (q.size() > 0) begin
      m_last_pc = q[0].pc; m_last_instr = q[0].instr;
    end
    if (rd) begin
      m_flush = m_flush + 32'(q.size());
      q.delete();
      if (mis) m_err = 1'b1;
      else     m_pc  = redirect_pc;
    end else begin
      if (pp) void'(q.pop_front());
      if (ps) begin
        q.push_back('{m_pc, rom(m_pc)});
        m_pc    = m_pc + 32'd4;
        m_fetch = m_fetch + 32'd1;
      end
    end
    m_state = ns;
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef IFETCH_PERF_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  // Pulse reset between negedges and leave all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
    vectors++; if (out_pc !== 32'd0)    begin miscompares++; $display("FAIL reset out_pc got %h exp 0", out_pc); end
    vectors++; if (out_instr !== 32'd0) begin miscompares++; $display("FAIL reset out_instr got %h exp 0", out_instr); end
    vectors++; if (state_o !== 2'd0)    begin miscompares++; $display("FAIL reset state got %0d exp 0", state_o); end
    vectors++; if (imem_addr !== 32'd0) begin miscompares++; $display("FAIL reset imem_addr got %h exp 0", imem_addr); end
    vectors++; if (misalign_err !== 1'b0 || fetch_cnt !== 32'd0 || flush_cnt !== 32'd0)
      begin miscompares++; $display("FAIL reset err/cnt got %0b %0d %0d exp 0 0 0", misalign_err, fetch_cnt, flush_cnt); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] epc[3];
    logic [31:0] ein[3];
    epc[0] = 32'd0; epc[1] = 32'd4; epc[2] = 32'd8;
    ein[0] = 32'h00500513; ein[1] = 32'h06400093; ein[2] = 32'h20000113;
    do_reset();
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    vectors++; if (state_o !== 2'd1 || out_valid !== 1'b0)
      begin miscompares++; $display("FAIL stream_first state/valid got %0d %0b exp 1 0", state_o, out_valid); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (out_valid !== 1'b1 || out_pc !== epc[i] || out_instr !== ein[i])
        begin miscompares++; $display("FAIL stream[%0d] got v=%0b pc=%h in=%h exp v=1 pc=%h in=%h", i, out_valid, out_pc, out_instr, epc[i], ein[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_full();
    do_reset();
    start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'd0)
      begin miscompares++; $display("FAIL stall head got v=%0b pc=%h exp v=1 pc=0", out_valid, out_pc); end
    vectors++; if (imem_addr !== 32'd8) begin miscompares++; $display("FAIL stall pc got %h exp 8", imem_addr); end
    vectors++; if (fetch_cnt !== perf(32'd2)) begin miscompares++; $display("FAIL stall fetch_cnt got %0d exp %0d", fetch_cnt, perf(32'd2)); end
  endtask

  // Continues from the full FIFO left by test_stall_full.
  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'd92; out_ready = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redirect mask got %0b exp 0", out_valid); end
    @(negedge clk); redirect_valid = 1'b0;
    #1;
    vectors++; if (imem_addr !== 32'd92 || out_valid !== 1'b0)
      begin miscompares++; $display("FAIL redirect pc/valid got %h %0b exp 5c 0", imem_addr, out_valid); end
    vectors++; if (flush_cnt !== perf(32'd2)) begin miscompares++; $display("FAIL redirect flush_cnt got %0d exp %0d", flush_cnt, perf(32'd2)); end
    @(negedge clk);
    #1;
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'd92 || out_instr !== 32'h00100513)
      begin miscompares++; $display("FAIL redirect target got v=%0b pc=%h in=%h exp v=1 pc=5c in=00100513", out_valid, out_pc, out_instr); end
    @(negedge clk);
  endtask

  // Continues from test_redirect: FIFO holds pc 96, pc_q = 100.
  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h32; out_ready = 1'b0;
    @(negedge clk); redirect_valid = 1'b0;
    #1;
    vectors++; if (misalign_err !== 1'b1 || state_o !== 2'd2)
      begin miscompares++; $display("FAIL misalign err/state got %0b %0d exp 1 2", misalign_err, state_o); end
    vectors++; if (out_valid !== 1'b0 || imem_addr !== 32'd100)
      begin miscompares++; $display("FAIL misalign fifo/pc got v=%0b pc=%h exp v=0 pc=64", out_valid, imem_addr); end
    vectors++; if (flush_cnt !== perf(32'd3)) begin miscompares++; $display("FAIL misalign flush_cnt got %0d exp %0d", flush_cnt, perf(32'd3)); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL misalign restart state got %0d exp 2", state_o); end
    @(negedge clk);
  endtask

  task automatic test_range_end();
    logic [31:0] seen_pc;
    logic [31:0] seen_in;
    seen_pc = 32'hFFFF_FFFF; seen_in = 32'd0;
    do_reset();
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'd80;
    @(negedge clk); redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (out_valid === 1'b1) begin seen_pc = out_pc; seen_in = out_instr; end
      @(negedge clk);
    end
    #1;
    vectors++; if (imem_addr !== 32'd100 || state_o !== 2'd1 || out_valid !== 1'b0)
      begin miscompares++; $display("FAIL range stop got pc=%h st=%0d v=%0b exp pc=64 st=1 v=0", imem_addr, state_o, out_valid); end
    vectors++; if (seen_pc !== 32'd96 || seen_in !== 32'h00008067)
      begin miscompares++; $display("FAIL range last got pc=%h in=%h exp 60 00008067", seen_pc, seen_in); end
    vectors++; if (out_pc !== 32'd96 || out_instr !== 32'h00008067)
      begin miscompares++; $display("FAIL range hold got pc=%h in=%h exp 60 00008067", out_pc, out_instr); end
    @(negedge clk);
  endtask

  task automatic test_halt_and_async_reset();
    do_reset();
    start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    halt_req = 1'b1; start = 1'b1;
    @(negedge clk); halt_req = 1'b0; start = 1'b0;
    #1;
    vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL halt_wins state got %0d exp 2", state_o); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || state_o !== 2'd0)
      begin miscompares++; $display("FAIL async_reset out got v=%0b pc=%h in=%h st=%0d exp 0 0 0 0", out_valid, out_pc, out_instr, state_o); end
    vectors++; if (imem_addr !== 32'd0 || misalign_err !== 1'b0 || fetch_cnt !== 32'd0 || flush_cnt !== 32'd0)
      begin miscompares++; $display("FAIL async_reset regs got pc=%h e=%0b f=%0d fl=%0d exp 0", imem_addr, misalign_err, fetch_cnt, flush_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- random traffic against the model ----------------
  task automatic test_random();
    bit          ev;
    logic [31:0] epc, ein;
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        start          = ($urandom_range(0, 3) == 0);
        halt_req       = ($urandom_range(0, 15) == 0);
        redirect_valid = ($urandom_range(0, 9) == 0);
        redirect_pc    = 32'($urandom_range(0, 31)) * 32'd4;
        if ($urandom_range(0, 15) == 0) redirect_pc = redirect_pc | 32'($urandom_range(1, 3));
        out_ready      = 1'($urandom_range(0, 1));
        #1;
        ev  = (q.size() > 0) && !redirect_valid;
        epc = (q.size() > 0) ? q[0].pc    : m_last_pc;
        ein = (q.size() > 0) ? q[0].instr : m_last_instr;
        vectors++; if (out_valid !== ev)
          begin miscompares++; $display("FAIL rand out_valid b%0d c%0d got %0b exp %0b", blk, c, out_valid, ev); end
        vectors++; if (out_pc !== epc || out_instr !== ein)
          begin miscompares++; $display("FAIL rand out_data b%0d c%0d got %h/%h exp %h/%h", blk, c, out_pc, out_instr, epc, ein); end
        vectors++; if (imem_addr !== m_pc)
          begin miscompares++; $display("FAIL rand pc b%0d c%0d got %h exp %h", blk, c, imem_addr, m_pc); end
        vectors++; if (state_o !== 2'(m_state) || misalign_err !== m_err)
          begin miscompares++; $display("FAIL rand state b%0d c%0d got %0d/%0b exp %0d/%0b", blk, c, state_o, misalign_err, m_state, m_err); end
        vectors++; if (fetch_cnt !== perf(m_fetch) || flush_cnt !== perf(m_flush))
          begin miscompares++; $display("FAIL rand cnt b%0d c%0d got %0d/%0d exp %0d/%0d", blk, c, fetch_cnt, flush_cnt, perf(m_fetch), perf(m_flush)); end
        model_edge();
        @(negedge clk);
      end
    end
    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_full();
    test_redirect();
    test_misalign();
    test_range_end();
    test_halt_and_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d vectors %0d miscompares", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
